// File: rtl/mem_arbiter_rr.sv
// Arbitrates NUM_CH requesters (round-robin or fixed priority) onto a single
// memory port with one outstanding transaction and a BUSY-phase timeout.
module mem_arbiter_rr #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned RR_MODE = 1,
    parameter int unsigned TIMEOUT = 255,
    localparam int unsigned STRB_W = DATA_W / 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_CH-1:0]          req_valid_i,
    output logic [NUM_CH-1:0]          req_ready_o,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_CH*STRB_W-1:0]   req_wstrb_i,
    input  logic [NUM_CH*DATA_W-1:0]   req_wdata_i,
    output logic [NUM_CH-1:0]          res_valid_o,
    output logic                       res_err_o,
    output logic [DATA_W-1:0]          res_rdata_o,
    output logic                       mem_valid_o,
    input  logic                       mem_ready_i,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic [STRB_W-1:0]          mem_wstrb_o,
    output logic [DATA_W-1:0]          mem_wdata_o,
    input  logic [DATA_W-1:0]          mem_rdata_i
);

    localparam int unsigned IDX_W = $clog2(NUM_CH);
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  start;
    logic [IDX_W-1:0]  sel;
    logic [IDX_W-1:0]  sel_next;
    logic              sel_found;
    logic [CNT_W-1:0]  cnt;

    // Fixed priority is a round-robin search that always starts at channel 0.
    assign start = (RR_MODE != 0) ? ptr : '0;

    // Scan from the highest search offset down so the first valid channel
    // after the start position wins.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        sel       = '0;
        sel_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = int'(start) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (req_valid_i[IDX_W'(idx)]) begin
                sel       = IDX_W'(idx);
                sel_found = 1'b1;
            end
        end
    end

    assign sel_next = (sel == IDX_W'(NUM_CH - 1)) ? '0 : sel + IDX_W'(1);

    assign req_ready_o = (rst_ni && (state == IDLE) && sel_found) ? (ONE_HOT0 << sel) : '0;

    // Transaction FSM: accept in IDLE, drive memory in BUSY, report in RESP.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            cnt         <= '0;
            mem_valid_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_wstrb_o <= '0;
            mem_wdata_o <= '0;
            res_valid_o <= '0;
            res_err_o   <= 1'b0;
            res_rdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        owner       <= sel;
                        ptr         <= sel_next;
                        cnt         <= '0;
                        mem_valid_o <= 1'b1;
                        mem_addr_o  <= req_addr_i[sel*ADDR_W +: ADDR_W];
                        mem_wstrb_o <= req_wstrb_i[sel*STRB_W +: STRB_W];
                        mem_wdata_o <= req_wdata_i[sel*DATA_W +: DATA_W];
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    // A ready in the final allowed cycle still completes normally.
                    if (mem_ready_i || (cnt == CNT_LAST)) begin
                        mem_valid_o <= 1'b0;
                        res_valid_o <= ONE_HOT0 << owner;
                        res_err_o   <= !mem_ready_i;
                        res_rdata_o <= mem_ready_i ? mem_rdata_i : '0;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    res_valid_o <= '0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: a round-robin and a fixed-priority instance share
// the memory-side stimulus; each transaction is checked cycle by cycle.
module tb_mem_arbiter_rr;

    localparam int unsigned N   = 3;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned TMO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0]    v_rr, v_fx;
    logic [N*AW-1:0] req_addr;
    logic [N*SW-1:0] req_wstrb;
    logic [N*DW-1:0] req_wdata;
    logic            mem_ready;
    logic [DW-1:0]   mem_rdata;

    logic [N-1:0]  rr_ready, rr_res_valid, fx_ready, fx_res_valid;
    logic          rr_res_err, fx_res_err, rr_mem_valid, fx_mem_valid;
    logic [DW-1:0] rr_res_rdata, fx_res_rdata, rr_mem_wdata, fx_mem_wdata;
    logic [AW-1:0] rr_mem_addr, fx_mem_addr;
    logic [SW-1:0] rr_mem_wstrb, fx_mem_wstrb;

    logic          use_fx;
    logic [N-1:0]  o_ready, o_res_valid;
    logic          o_res_err, o_mem_valid;
    logic [DW-1:0] o_res_rdata, o_mem_wdata;
    logic [AW-1:0] o_mem_addr;
    logic [SW-1:0] o_mem_wstrb;

    int total = 0;
    int bad   = 0;
    int rr_ptr = 0;

    typedef struct {
        bit          fx;
        logic [2:0]  valid;
        int          wt;
        logic [31:0] rdata;
        logic [31:0] addr;
        bit          rd;
        int          g;
    } vec_t;

    vec_t tbl[16];

    mem_arbiter_rr #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .TIMEOUT(TMO)) u_rr (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(v_rr), .req_ready_o(rr_ready),
        .req_addr_i(req_addr), .req_wstrb_i(req_wstrb), .req_wdata_i(req_wdata),
        .res_valid_o(rr_res_valid), .res_err_o(rr_res_err), .res_rdata_o(rr_res_rdata),
        .mem_valid_o(rr_mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(rr_mem_addr),
        .mem_wstrb_o(rr_mem_wstrb), .mem_wdata_o(rr_mem_wdata), .mem_rdata_i(mem_rdata)
    );

    mem_arbiter_rr #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .TIMEOUT(TMO)) u_fx (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(v_fx), .req_ready_o(fx_ready),
        .req_addr_i(req_addr), .req_wstrb_i(req_wstrb), .req_wdata_i(req_wdata),
        .res_valid_o(fx_res_valid), .res_err_o(fx_res_err), .res_rdata_o(fx_res_rdata),
        .mem_valid_o(fx_mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(fx_mem_addr),
        .mem_wstrb_o(fx_mem_wstrb), .mem_wdata_o(fx_mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    always_comb begin
        o_ready     = use_fx ? fx_ready     : rr_ready;
        o_res_valid = use_fx ? fx_res_valid : rr_res_valid;
        o_res_err   = use_fx ? fx_res_err   : rr_res_err;
        o_res_rdata = use_fx ? fx_res_rdata : rr_res_rdata;
        o_mem_valid = use_fx ? fx_mem_valid : rr_mem_valid;
        o_mem_addr  = use_fx ? fx_mem_addr  : rr_mem_addr;
        o_mem_wstrb = use_fx ? fx_mem_wstrb : rr_mem_wstrb;
        o_mem_wdata = use_fx ? fx_mem_wdata : rr_mem_wdata;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: first pending channel at or after pointer p, wrapping.
    function automatic int pick(input logic [2:0] v, input int p);
        for (int k = 0; k < 3; k++) begin
            if (v[(p + k) % 3]) return (p + k) % 3;
        end
        return -1;
    endfunction

    task automatic set_valid(input bit fx, input logic [2:0] v);
        if (fx) begin
            v_fx = v;
            v_rr = '0;
        end else begin
            v_rr = v;
            v_fx = '0;
        end
    endtask

    // One full transaction: IDLE grant, BUSY phase of wt+1 cycles (or timeout), RESP.
    task automatic txn(input bit fx, input logic [2:0] valid, input int wt,
                       input logic [31:0] rd_fix, input logic [31:0] addr_fix,
                       input bit rd_only, input int exp_g);
        logic [AW-1:0] a[3];
        logic [SW-1:0] s[3];
        logic [DW-1:0] d[3];
        logic [DW-1:0] rdv;
        logic [2:0]    oh;
        bit            exp_err;
        int            busy_n;
        for (int c = 0; c < 3; c++) begin
            a[c] = (addr_fix != 0) ? addr_fix : $urandom;
            s[c] = rd_only ? '0 : SW'($urandom);
            d[c] = $urandom;
        end
        oh      = 3'b001 << exp_g;
        exp_err = (wt + 1) > int'(TMO);
        busy_n  = exp_err ? int'(TMO) : wt + 1;
        rdv     = '0;
        @(negedge clk);
        use_fx = fx;
        for (int c = 0; c < 3; c++) begin
            req_addr[c*AW +: AW]  = a[c];
            req_wstrb[c*SW +: SW] = s[c];
            req_wdata[c*DW +: DW] = d[c];
        end
        set_valid(fx, valid);
        mem_ready = 1'($urandom);
        mem_rdata = $urandom;
        #1;
        check("grant", o_ready, oh);
        check("idle_mem_valid", o_mem_valid, 0);
        check("idle_res_valid", o_res_valid, 0);
        for (int k = 1; k <= busy_n; k++) begin
            @(negedge clk);
            set_valid(fx, valid & ~oh);
            mem_ready = !exp_err && (k == busy_n);
            mem_rdata = (k == busy_n && rd_fix != 0) ? rd_fix : $urandom;
            if (mem_ready) rdv = mem_rdata;
            #1;
            check("busy_mem_valid", o_mem_valid, 1);
            check("busy_addr", o_mem_addr, a[exp_g]);
            check("busy_wstrb", o_mem_wstrb, s[exp_g]);
            check("busy_wdata", o_mem_wdata, d[exp_g]);
            check("busy_ready", o_ready, 0);
            check("busy_res_valid", o_res_valid, 0);
        end
        @(negedge clk);
        mem_ready = 1'($urandom);
        mem_rdata = $urandom;
        #1;
        check("resp_valid", o_res_valid, oh);
        check("resp_err", o_res_err, exp_err);
        check("resp_rdata", o_res_rdata, exp_err ? '0 : rdv);
        check("resp_mem_valid", o_mem_valid, 0);
        check("resp_ready", o_ready, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         g;
        bit         f;
        logic [2:0] v;
        int         wt;

        tbl[0]  = '{1'b0, 3'b111, 0, 32'h0, 32'h0, 1'b0, 0};
        tbl[1]  = '{1'b0, 3'b111, 0, 32'h0, 32'h0, 1'b0, 1};
        tbl[2]  = '{1'b0, 3'b111, 0, 32'h0, 32'h0, 1'b0, 2};
        tbl[3]  = '{1'b0, 3'b111, 0, 32'h0, 32'h0, 1'b0, 0};
        tbl[4]  = '{1'b0, 3'b111, 1, 32'h0, 32'h0, 1'b0, 1};
        tbl[5]  = '{1'b0, 3'b111, 2, 32'h0, 32'h0, 1'b0, 2};
        tbl[6]  = '{1'b0, 3'b010, 3, 32'hDEAD_BEEF, 32'h8000_0040, 1'b1, 1};
        tbl[7]  = '{1'b0, 3'b100, 7, 32'h1234_5678, 32'h0, 1'b0, 2};
        tbl[8]  = '{1'b0, 3'b001, 8, 32'h0, 32'h0, 1'b0, 0};
        tbl[9]  = '{1'b0, 3'b011, 0, 32'h0, 32'h0, 1'b0, 1};
        tbl[10] = '{1'b0, 3'b011, 0, 32'h0, 32'h0, 1'b0, 0};
        tbl[11] = '{1'b1, 3'b101, 1, 32'h0, 32'h0, 1'b0, 0};
        tbl[12] = '{1'b1, 3'b101, 0, 32'h0, 32'h0, 1'b0, 0};
        tbl[13] = '{1'b1, 3'b101, 9, 32'h0, 32'h0, 1'b0, 0};
        tbl[14] = '{1'b1, 3'b100, 0, 32'h0, 32'h0, 1'b0, 2};
        tbl[15] = '{1'b1, 3'b110, 2, 32'h0, 32'h0, 1'b0, 1};

        use_fx = 1'b0;
        v_rr = '0; v_fx = '0;
        req_addr = '0; req_wstrb = '0; req_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rr_mem_valid", rr_mem_valid, 0);
        check("rst_rr_mem_addr", rr_mem_addr, 0);
        check("rst_rr_mem_wstrb", rr_mem_wstrb, 0);
        check("rst_rr_mem_wdata", rr_mem_wdata, 0);
        check("rst_rr_res_valid", rr_res_valid, 0);
        check("rst_rr_res_err", rr_res_err, 0);
        check("rst_rr_res_rdata", rr_res_rdata, 0);
        check("rst_rr_ready", rr_ready, 0);
        check("rst_fx_mem_valid", fx_mem_valid, 0);
        check("rst_fx_res_valid", fx_res_valid, 0);
        rst_n = 1'b1;

        for (int r = 0; r < 16; r++) begin
            txn(tbl[r].fx, tbl[r].valid, tbl[r].wt, tbl[r].rdata, tbl[r].addr, tbl[r].rd, tbl[r].g);
            if (!tbl[r].fx) rr_ptr = (tbl[r].g + 1) % 3;
        end

        // Reset in the second BUSY cycle of a write aborts it and rewinds the pointer.
        g = pick(3'b111, rr_ptr);
        @(negedge clk);
        use_fx = 1'b0;
        req_wstrb = '1;
        set_valid(1'b0, 3'b111);
        mem_ready = 1'b0;
        #1;
        check("abort_grant", o_ready, 3'b001 << g);
        @(negedge clk);
        set_valid(1'b0, 3'b111 & ~(3'b001 << g));
        #1;
        check("abort_busy1", o_mem_valid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy2", o_mem_valid, 1);
        @(negedge clk);
        rst_n = 1'b1;
        set_valid(1'b0, 3'b111);
        #1;
        check("abort_mem_valid", o_mem_valid, 0);
        check("abort_res_valid", o_res_valid, 0);
        check("abort_mem_addr", o_mem_addr, 0);
        check("abort_mem_wstrb", o_mem_wstrb, 0);
        check("abort_ready_after_rst", o_ready, 3'b001);
        set_valid(1'b0, 3'b000);
        rr_ptr = 0;
        txn(1'b0, 3'b111, 0, 32'h0, 32'h0, 1'b0, 0);
        rr_ptr = 1;

        for (int t = 0; t < 40; t++) begin
            f  = 1'($urandom);
            v  = 3'($urandom_range(1, 7));
            wt = $urandom_range(0, 9);
            g  = f ? pick(v, 0) : pick(v, rr_ptr);
            txn(f, v, wt, 32'h0, 32'h0, 1'($urandom), g);
            if (!f) rr_ptr = (g + 1) % 3;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_rr.md
MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

Interface
REQ-001 Parameter NUM_CH, default 2, number of requester channels (legal 2..8).
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter DATA_W, default 128, block data width; STRB_W = DATA_W/8.
REQ-004 Parameter RR_MODE, default 1; 1 = round-robin, 0 = fixed priority (channel 0 highest).
REQ-005 Parameter TIMEOUT, default 255, maximum BUSY cycles before forced error completion (legal 1..65535).
REQ-006 Clocking: one clock; reset is synchronous and active-low.
REQ-007 clk_i  in  1  clock; all state updates on rising edge.
REQ-008 rst_ni  in  1  synchronous active-low reset.
REQ-009 req_valid_i  in  NUM_CH  per-channel request pending; held until accepted.
REQ-010 req_ready_o  out  NUM_CH  one-hot accept pulse; request taken when valid and ready both high.
REQ-011 req_addr_i  in  NUM_CH*ADDR_W  packed per-channel address.
REQ-012 req_wstrb_i  in  NUM_CH*STRB_W  packed byte strobes; all-zero = read.
REQ-013 req_wdata_i  in  NUM_CH*DATA_W  packed write data.
REQ-014 res_valid_o  out  NUM_CH  one-hot single-cycle completion pulse to owning channel.
REQ-015 res_err_o  out  1  completion was a timeout; qualified by any res_valid_o bit.
REQ-016 res_rdata_o  out  DATA_W  shared read data; qualified by res_valid_o.
REQ-017 mem_valid_o / mem_ready_i / mem_addr_o (ADDR_W) / mem_wstrb_o (STRB_W) / mem_wdata_o (DATA_W) / mem_rdata_i (DATA_W): memory port; transfer completes in the cycle mem_valid_o and mem_ready_i are both high.

Function
REQ-018 FSM states IDLE, BUSY, RESP; one outstanding transaction maximum.
REQ-019 IDLE: if any req_valid_i, assert req_ready_o for the selected channel only (combinational), latch its addr/wstrb/wdata and index, go BUSY; else stay IDLE, req_ready_o = 0.
REQ-020 Fixed mode: lowest-index valid channel selected.
REQ-021 Round-robin mode: search starts at pointer P, wraps NUM_CH-1 -> 0; on grant to g, P <= (g+1) mod NUM_CH; P unchanged when no grant.
REQ-022 BUSY: mem_valid_o = 1 with latched fields held stable; req_ready_o = 0 for all channels.
REQ-023 BUSY and mem_ready_i: latch mem_rdata_i, clear error flag, go RESP.
REQ-024 Timeout counter cleared on entry to BUSY, increments each BUSY cycle without mem_ready_i; reaching TIMEOUT without mem_ready_i -> latch rdata = 0, set error flag, go RESP, mem_valid_o drops next cycle.
REQ-025 mem_ready_i in the same cycle the counter reaches TIMEOUT: normal completion, no error.
REQ-026 RESP: res_valid_o[owner] = 1 for exactly one cycle with res_rdata_o/res_err_o; return to IDLE; no new grant in RESP.
REQ-027 Latency: accept at cycle t, mem_valid_o high from t+1; mem_ready_i at cycle m -> res_valid_o at m+1; earliest next accept m+2.
REQ-028 mem_ready_i outside BUSY ignored; req_valid_i dropping after acceptance has no effect.
REQ-029 Channel re-requesting immediately after its own response is arbitrated normally (round-robin gives other pending channels precedence).

Reset
REQ-030 rst_ni low at a clock edge: state IDLE, P = 0, counter 0, error flag 0, latched fields 0.
REQ-031 Output values during/after reset: req_ready_o 0 unless IDLE grant, mem_valid_o 0, mem_addr_o/mem_wstrb_o/mem_wdata_o 0, res_valid_o 0, res_err_o 0, res_rdata_o 0.
REQ-032 Reset mid-BUSY aborts the transaction: no res_valid_o issued; mem_valid_o low the cycle after the reset edge.

Verification
REQ-033 RR_MODE=1, NUM_CH=3, all three valid continuously, mem_ready_i one cycle after each mem_valid_o -> grant order 0,1,2,0,1,2; each res_valid_o pulse one cycle wide.
REQ-034 RR_MODE=0, channels 0 and 2 valid continuously -> channel 0 always granted, channel 2 never, until channel 0 drops.
REQ-035 Read ch1 addr 0x8000_0040, wstrb 0, mem_ready_i after 4 BUSY cycles with rdata 0xDEAD_BEEF -> mem_addr_o 0x8000_0040 stable 4 cycles, res_valid_o = 3'b010 next cycle, res_rdata_o 0xDEAD_BEEF, res_err_o 0.
REQ-036 TIMEOUT=8, mem_ready_i never asserted -> after 8 BUSY cycles res_valid_o to owner with res_err_o 1, res_rdata_o 0; FSM returns IDLE.
REQ-037 TIMEOUT=8, mem_ready_i in the 8th BUSY cycle -> res_err_o 0, rdata returned.
REQ-038 Reset asserted in 2nd BUSY cycle of a write -> no res_valid_o, mem_valid_o 0 after reset edge, P = 0, next grant follows reset priority.
